servo_cmd_loader: RTL and testbench
===================================

Name: servo_cmd_loader

Overview:
Upstream feeder for the 8-channel servo PWM generator. Parses a framed byte stream from the flight-control processor link (UART/SPI byte receiver) into eight 15-bit pulse widths in 1 us units, clamped to the safe servo range. On each good frame it asserts a one-cycle data_update_flag, so the PWM stage latches all eight channels together at its next period boundary.

Parameters:
WORDSIZE, 15, pulse width word size in bits (1 LSB = 1 us)
PW_MIN, 15'd800, lower clamp applied to every channel
PW_MAX, 15'd2200, upper clamp applied to every channel
PW_DEFAULT, 15'd1500, reset value of every channel output
TIMEOUT_US, 2000, inter-byte timeout in pwm_clk ticks
HDR0, 8'hA5, first header byte
HDR1, 8'h5A, second header byte

Ports:
clk  in  1  system clock, default 24 MHz
rst  in  1  synchronous, active-high reset
pwm_clk  in  1  1 MHz tick, one clk cycle wide, used for the timeout
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle
pulse_width_ch1..pulse_width_ch8  out  WORDSIZE each  committed, clamped widths
data_update_flag  out  1  one-cycle pulse; all 8 outputs updated this cycle
frame_err  out  1  one-cycle pulse on checksum error or timeout

Behaviour:
- Frame layout: HDR0, HDR1, 16 data bytes, checksum byte. The data bytes are ch1_hi, ch1_lo, ... ch8_hi, ch8_lo.
- Each channel value is {hi[6:0], lo[7:0]}; hi[7] is ignored.
- checksum = 8-bit modulo-256 sum of the 16 data bytes. Header bytes are excluded.
- FSM states: IDLE, GOT_H0, DATA, CSUM.
  - IDLE: byte==HDR0 -> GOT_H0; otherwise stay in IDLE.
  - GOT_H0: byte==HDR1 -> DATA with idx=0 and sum=0. byte==HDR0 -> stay in GOT_H0. Any other byte -> IDLE, with no frame_err.
  - DATA: each byte is written to staging[idx] and added to sum; idx increments. When idx==15 is accepted -> CSUM.
  - CSUM: byte==sum -> commit, then IDLE. Mismatch -> frame_err for 1 cycle, then IDLE. Outputs are unchanged on a mismatch.
- State changes only on cycles with rx_valid=1, except for the timeout.
- Commit: in the clk cycle after the checksum byte strobe, all 8 outputs load clamp(staging) and data_update_flag=1 in that same cycle. Latency from checksum strobe to new outputs is 1 clk.
- clamp(v): v<PW_MIN -> PW_MIN; v>PW_MAX -> PW_MAX; otherwise v. Bounds are inclusive.
- Outputs hold their value between commits. A partial frame never changes any output.
- Timeout: a counter (at least 12 bits wide) clears on every rx_valid and increments on each pwm_clk while the state is not IDLE.
  - When the counter reaches TIMEOUT_US: frame_err for 1 cycle, state -> IDLE, staging discarded.
  - The counter is held at 0 in IDLE.
- rx_valid and pwm_clk in the same cycle: the byte is processed, the counter clears, and the tick is ignored.
- A timeout and rx_valid can never fire in the same cycle; the byte wins.
- rst (synchronous): state=IDLE, idx=0, sum=0, counter=0, all pulse_width_chN=PW_DEFAULT, data_update_flag=0, frame_err=0.
- A reset mid-frame discards staging with no flag and no error.
- Back-to-back frames: a byte arriving in the commit cycle is processed by IDLE normally.
- data_update_flag and frame_err are never high together.

Test Plan:
- Good frame with channels 1000,1100,...,1700 (0x03E8 ...) and correct sum -> 1 clk after the checksum strobe, ch1..ch8 = 1000..1700 and data_update_flag high for exactly 1 cycle; frame_err stays 0.
- Frame with ch1=500, ch2=3000, ch3=800, ch4=2200 -> outputs 800, 2200, 800, 2200; the boundaries pass unchanged.
- Good frame, then an identical frame with checksum+1 -> frame_err pulses once, outputs hold the first frame's values, and no update flag.
- Header, 6 data bytes, then silence -> frame_err exactly 2000 pwm_clk ticks after the last byte, outputs unchanged. A subsequent good frame is accepted.
- Byte stream A5 A5 5A + valid frame -> accepted. Stream A5 33 + valid frame -> accepted, no frame_err.
- Assert rst after 10 data bytes of a frame -> all outputs 1500, no flags. The remaining bytes plus checksum produce no commit.

Source files
------------

// File: rtl/servo_cmd_loader.sv
// servo_cmd_loader: parses framed byte stream into eight clamped servo pulse
// widths (1 us units), committing all channels together on a good checksum.

// Per-channel saturating clamp into the safe servo window (inclusive bounds).
module servo_clamp #(
    parameter int              W   = 15,
    parameter logic [W-1:0]    MIN = 15'd800,
    parameter logic [W-1:0]    MAX = 15'd2200
) (
    input  logic [W-1:0] v,
    output logic [W-1:0] q
);
    assign q = (v < MIN) ? MIN : ((v > MAX) ? MAX : v);
endmodule

module servo_cmd_loader #(
    parameter int                   WORDSIZE   = 15,
    parameter logic [WORDSIZE-1:0]  PW_MIN     = 15'd800,
    parameter logic [WORDSIZE-1:0]  PW_MAX     = 15'd2200,
    parameter logic [WORDSIZE-1:0]  PW_DEFAULT = 15'd1500,
    parameter int                   TIMEOUT_US = 2000,
    parameter logic [7:0]           HDR0       = 8'hA5,
    parameter logic [7:0]           HDR1       = 8'h5A
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwm_clk,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [WORDSIZE-1:0] pulse_width_ch1,
    output logic [WORDSIZE-1:0] pulse_width_ch2,
    output logic [WORDSIZE-1:0] pulse_width_ch3,
    output logic [WORDSIZE-1:0] pulse_width_ch4,
    output logic [WORDSIZE-1:0] pulse_width_ch5,
    output logic [WORDSIZE-1:0] pulse_width_ch6,
    output logic [WORDSIZE-1:0] pulse_width_ch7,
    output logic [WORDSIZE-1:0] pulse_width_ch8,
    output logic                data_update_flag,
    output logic                frame_err
);
    localparam int NUM_CH = 8;
    // Counter must hold TIMEOUT_US and be at least 12 bits.
    localparam int CNT_W  = ($clog2(TIMEOUT_US + 1) > 12) ? $clog2(TIMEOUT_US + 1) : 12;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_US - 1);

    typedef enum logic [1:0] {IDLE, GOT_H0, DATA, CSUM} state_t;

    state_t                          state, state_nxt;
    logic [3:0]                      idx;
    logic [7:0]                      sum;
    logic [CNT_W-1:0]                to_cnt;
    logic [15:0][7:0]                staging;
    logic [NUM_CH-1:0][WORDSIZE-1:0] pw_q, pw_clamped;
    logic                            hdr_done, data_wr, csum_ok, csum_bad, timeout;

    // Clamp every staged channel in parallel; hi[7] is dropped here.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        servo_clamp #(.W(WORDSIZE), .MIN(PW_MIN), .MAX(PW_MAX)) u_clamp (
            .v (WORDSIZE'({staging[2*ch][6:0], staging[2*ch+1]})),
            .q (pw_clamped[ch])
        );
    end

    assign pulse_width_ch1 = pw_q[0];
    assign pulse_width_ch2 = pw_q[1];
    assign pulse_width_ch3 = pw_q[2];
    assign pulse_width_ch4 = pw_q[3];
    assign pulse_width_ch5 = pw_q[4];
    assign pulse_width_ch6 = pw_q[5];
    assign pulse_width_ch7 = pw_q[6];
    assign pulse_width_ch8 = pw_q[7];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; a byte always takes priority over a pending timeout.
    always_comb begin
        state_nxt = state;
        hdr_done  = 1'b0;
        data_wr   = 1'b0;
        csum_ok   = 1'b0;
        csum_bad  = 1'b0;
        timeout   = 1'b0;
        if (rx_valid) begin
            case (state)
                IDLE:   if (rx_data == HDR0) state_nxt = GOT_H0;
                GOT_H0: begin
                    if (rx_data == HDR1) begin
                        state_nxt = DATA;
                        hdr_done  = 1'b1;
                    end else if (rx_data != HDR0) begin
                        state_nxt = IDLE;
                    end
                end
                DATA: begin
                    data_wr = 1'b1;
                    if (idx == 4'd15) state_nxt = CSUM;
                end
                CSUM: begin
                    state_nxt = IDLE;
                    csum_ok   = (rx_data == sum);
                    csum_bad  = (rx_data != sum);
                end
                default: state_nxt = IDLE;
            endcase
        end else if (state != IDLE && pwm_clk && to_cnt == TO_LAST) begin
            timeout   = 1'b1;
            state_nxt = IDLE;
        end
    end

    // Frame bookkeeping, timeout counter, committed outputs and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            sum              <= '0;
            to_cnt           <= '0;
            pw_q             <= {NUM_CH{PW_DEFAULT}};
            data_update_flag <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            data_update_flag <= csum_ok;
            frame_err        <= csum_bad | timeout;
            if (rx_valid || state == IDLE || timeout) to_cnt <= '0;
            else if (pwm_clk)                         to_cnt <= to_cnt + 1'b1;
            if (hdr_done) begin
                idx <= '0;
                sum <= '0;
            end else if (data_wr) begin
                idx <= idx + 4'd1;
                sum <= sum + rx_data;
            end
            if (csum_ok) pw_q <= pw_clamped;
        end
    end

    // Staging bytes need no reset: they only reach outputs after a full frame.
    always_ff @(posedge clk) begin
        if (data_wr) staging[idx] <= rx_data;
    end
endmodule

// File: tb/tb_servo_cmd_loader.sv
// Self-checking bench for servo_cmd_loader: table-driven frames with a
// scoreboard of expected commits, plus timeout, header and reset sequences.
module tb_servo_cmd_loader;
    typedef logic [7:0][14:0] chans_t;
    typedef struct packed {
        chans_t ch;
        chans_t exp;
        logic   hi7;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, rx_valid = 1'b0;
    logic        auto_tick = 1'b0, man_tick = 1'b0, tick_en = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic [1:0]  tick_div = 2'd0;
    logic        pwm_clk;
    logic [14:0] pw1, pw2, pw3, pw4, pw5, pw6, pw7, pw8;
    logic        data_update_flag, frame_err;
    chans_t      pw;

    int checks = 0, failures = 0;
    int flag_cnt = 0, err_cnt = 0, both_cnt = 0;
    int exp_flags = 0, exp_errs = 0;
    chans_t sb[$];
    chans_t last_exp;
    vec_t   vecs[4];

    servo_cmd_loader dut (
        .clk(clk), .rst(rst), .pwm_clk(pwm_clk), .rx_data(rx_data), .rx_valid(rx_valid),
        .pulse_width_ch1(pw1), .pulse_width_ch2(pw2), .pulse_width_ch3(pw3),
        .pulse_width_ch4(pw4), .pulse_width_ch5(pw5), .pulse_width_ch6(pw6),
        .pulse_width_ch7(pw7), .pulse_width_ch8(pw8),
        .data_update_flag(data_update_flag), .frame_err(frame_err)
    );

    assign pw      = {pw8, pw7, pw6, pw5, pw4, pw3, pw2, pw1};
    assign pwm_clk = tick_en ? auto_tick : man_tick;

    always #5 clk = ~clk;

    // Free-running 1-in-4 tick, so ticks often coincide with byte strobes.
    always @(negedge clk) begin
        tick_div  = tick_div + 2'd1;
        auto_tick = (tick_div == 2'd0);
    end

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (data_update_flag)             flag_cnt = flag_cnt + 1;
        if (frame_err)                    err_cnt  = err_cnt + 1;
        if (data_update_flag && frame_err) both_cnt = both_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_pw(input string name, input chans_t exp);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_ch%0d", name, i + 1), 32'(pw[i]), 32'(exp[i]));
    endtask

    function automatic chans_t pk(input int a, b, c, d, e, f, g, h);
        chans_t r;
        r[0] = 15'(a); r[1] = 15'(b); r[2] = 15'(c); r[3] = 15'(d);
        r[4] = 15'(e); r[5] = 15'(f); r[6] = 15'(g); r[7] = 15'(h);
        return r;
    endfunction

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Sends one complete frame; caller pushes the expected commit when good.
    task automatic send_frame(input chans_t ch, input logic hi7, input int delta, input logic good);
        logic [7:0] s, hb;
        chans_t     e;
        s = 8'h00;
        send(8'hA5);
        send(8'h5A);
        for (int i = 0; i < 8; i++) begin
            hb = {hi7, ch[i][14:8]};
            send(hb);
            send(ch[i][7:0]);
            s = s + hb + ch[i][7:0];
        end
        send(s + 8'(delta));
        chk("update_flag", 32'(data_update_flag), 32'(good));
        chk("frame_err", 32'(frame_err), 32'(!good));
        if (data_update_flag) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_pw("commit", e);
            end
        end
        if (good) exp_flags = exp_flags + 1;
        else      exp_errs  = exp_errs + 1;
        @(negedge clk);
        chk("flag_one_cycle", 32'(data_update_flag), 32'd0);
        chk("err_one_cycle", 32'(frame_err), 32'd0);
    endtask

    initial begin
        logic early;
        vecs[0] = '{ch: pk(1000, 1100, 1200, 1300, 1400, 1500, 1600, 1700),
                    exp: pk(1000, 1100, 1200, 1300, 1400, 1500, 1600, 1700), hi7: 1'b0};
        vecs[1] = '{ch: pk(500, 3000, 800, 2200, 799, 2201, 1500, 0),
                    exp: pk(800, 2200, 800, 2200, 800, 2200, 1500, 800), hi7: 1'b0};
        vecs[2] = '{ch: pk(1234, 801, 2199, 32767, 1999, 900, 2100, 1600),
                    exp: pk(1234, 801, 2199, 2200, 1999, 900, 2100, 1600), hi7: 1'b1};
        vecs[3] = '{ch: pk(32767, 1, 0, 1800, 1801, 2000, 1000, 1100),
                    exp: pk(2200, 800, 800, 1800, 1801, 2000, 1000, 1100), hi7: 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_pw("reset", pk(1500, 1500, 1500, 1500, 1500, 1500, 1500, 1500));
        chk("reset_flag", 32'(data_update_flag), 32'd0);
        chk("reset_err", 32'(frame_err), 32'd0);

        // Table of good frames, including clamp boundaries and hi[7] set.
        for (int v = 0; v < 4; v++) begin
            sb.push_back(vecs[v].exp);
            send_frame(vecs[v].ch, vecs[v].hi7, 0, 1'b1);
            last_exp = vecs[v].exp;
            repeat (3) @(negedge clk);
        end

        // Good frame then same frame with bad checksum: outputs hold.
        sb.push_back(vecs[0].exp);
        send_frame(vecs[0].ch, 1'b0, 0, 1'b1);
        last_exp = vecs[0].exp;
        send_frame(vecs[0].ch, 1'b0, 1, 1'b0);
        chk_pw("bad_csum_hold", last_exp);

        // Partial frame then silence: frame_err on exactly the 2000th tick.
        tick_en = 1'b0;
        @(negedge clk);
        send(8'hA5); send(8'h5A);
        for (int i = 0; i < 6; i++) send(8'h11);
        early = 1'b0;
        for (int t = 1; t <= 2000; t++) begin
            man_tick = 1'b1;
            @(negedge clk);
            man_tick = 1'b0;
            if (t < 2000) begin
                if (frame_err) early = 1'b1;
                @(negedge clk);
                if (frame_err) early = 1'b1;
            end
        end
        chk("timeout_early", 32'(early), 32'd0);
        chk("timeout_err", 32'(frame_err), 32'd1);
        chk("timeout_flag", 32'(data_update_flag), 32'd0);
        exp_errs = exp_errs + 1;
        @(negedge clk);
        chk("timeout_err_one_cycle", 32'(frame_err), 32'd0);
        chk_pw("timeout_hold", last_exp);
        tick_en = 1'b1;
        sb.push_back(vecs[3].exp);
        send_frame(vecs[3].ch, 1'b0, 0, 1'b1);
        last_exp = vecs[3].exp;

        // Repeated HDR0 and a broken header both resync without error.
        send(8'hA5);
        sb.push_back(vecs[1].exp);
        send_frame(vecs[1].ch, 1'b0, 0, 1'b1);
        send(8'hA5); send(8'h33);
        sb.push_back(vecs[0].exp);
        send_frame(vecs[0].ch, 1'b0, 0, 1'b1);
        last_exp = vecs[0].exp;
        chk("hdr_errs", 32'(err_cnt), 32'(exp_errs));

        // Reset after 10 data bytes; the tail of that frame must not commit.
        send(8'hA5); send(8'h5A);
        for (int i = 0; i < 5; i++) begin
            send({1'b0, vecs[3].ch[i][14:8]});
            send(vecs[3].ch[i][7:0]);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_pw("midframe_reset", pk(1500, 1500, 1500, 1500, 1500, 1500, 1500, 1500));
        chk("midframe_reset_flag", 32'(data_update_flag), 32'd0);
        for (int i = 5; i < 8; i++) begin
            send({1'b0, vecs[0].ch[i][14:8]});
            send(vecs[0].ch[i][7:0]);
        end
        send(8'h56);
        repeat (2) @(negedge clk);
        chk_pw("post_reset_hold", pk(1500, 1500, 1500, 1500, 1500, 1500, 1500, 1500));

        chk("total_flags", 32'(flag_cnt), 32'(exp_flags));
        chk("total_errs", 32'(err_cnt), 32'(exp_errs));
        chk("flag_err_overlap", 32'(both_cnt), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
